masked_inv_prng: RTL

- Randomness source for the masked GF(2^8) inverter pipeline; it is the producer side of the inverter's `in_random` bus.
- Expands a 128-bit seed into `OUT_WIDTH` fresh bits per enabled cycle, using a 128-bit LFSR advanced `OUT_WIDTH` steps per cycle.
- The seed is loaded over a 32-bit valid/ready port. A warm-up phase discards early output, and `out_valid` qualifies every word.
- Sits between the top-level seed/TRNG interface and one or more inverter instances.

---
 rtl/masked_inv_prng.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/masked_inv_prng.sv
// masked_inv_prng: randomness source feeding the masked GF(2^8) inverter.
// A 128-bit LFSR is loaded from four 32-bit seed beats, runs a warm-up phase
// that discards early output, then advances OUT_WIDTH steps per enabled cycle
// and presents the low OUT_WIDTH bits as a registered word qualified by
// out_valid.
// Optional feature macro: MASKED_PRNG_HEALTH_EN (repeated-word / zero-state
// health monitor driving a sticky out_error).
module masked_inv_prng #(
  parameter int OUT_WIDTH     = 64,
  parameter int WARMUP_CYCLES = 16,
  parameter int REPEAT_LIMIT  = 4
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic [31:0]          in_seed,
  input  logic                 in_seed_valid,
  output logic                 out_seed_ready,
  input  logic                 in_reseed,
  input  logic                 in_enable,
  output logic [OUT_WIDTH-1:0] out_random,
  output logic                 out_valid,
  output logic                 out_error
);

  // Reject configurations outside the supported parameter ranges at elaboration.
  generate
    if (OUT_WIDTH < 1 || OUT_WIDTH > 128 || WARMUP_CYCLES > 255 ||
        REPEAT_LIMIT < 2 || REPEAT_LIMIT > 15) begin : g_param_check
      $error("masked_inv_prng: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } fsm_t;

  // Last warm-up count value; unused when WARMUP_CYCLES is zero.
  localparam logic [7:0] WARM_LAST = (WARMUP_CYCLES > 0) ? 8'(WARMUP_CYCLES - 1) : 8'd0;

  fsm_t                 fsm_q, fsm_d;
  logic [127:0]         state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [7:0]           warm_q, warm_d;
  logic [OUT_WIDTH-1:0] random_q, random_d;
  logic                 valid_q, valid_d;
  logic [127:0]         adv;
  logic [127:0]         seed_full;

`ifdef MASKED_PRNG_HEALTH_EN
  localparam logic [3:0] REP_LAST = 4'(REPEAT_LIMIT - 1);
  logic [3:0] rep_q, rep_d, rep_next;
  logic       have_prev_q, have_prev_d;
  logic       error_q, error_d;
`endif

  // One LFSR step: shift left, feedback from taps 127, 125, 100, 98.
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  // Unrolled advance: OUT_WIDTH LFSR steps applied to the current state.
  always_comb begin
    adv = state_q;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      adv = lfsr_step(adv);
    end
  end

  // Seed handshake: a beat transfers on a rising edge where in_seed_valid and
  // out_seed_ready are both high; ready is high exactly while in SEED, and a
  // beat offered in the same cycle as in_reseed is dropped.
  assign out_seed_ready = (fsm_q == ST_SEED);
  assign out_random     = random_q;
  assign out_valid      = valid_q;
`ifdef MASKED_PRNG_HEALTH_EN
  assign out_error      = error_q;
`else
  assign out_error      = 1'b0;
`endif

  // Next-state and datapath decisions for SEED / WARMUP / RUN.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    beat_d    = beat_q;
    warm_d    = warm_q;
    random_d  = random_q;
    valid_d   = 1'b0;
    seed_full = {in_seed, state_q[95:0]};
`ifdef MASKED_PRNG_HEALTH_EN
    rep_d       = rep_q;
    rep_next    = 4'd0;
    have_prev_d = have_prev_q;
    error_d     = error_q;
`endif
    unique case (fsm_q)
      ST_SEED: begin
        random_d = '0;
`ifdef MASKED_PRNG_HEALTH_EN
        rep_d       = 4'd0;
        have_prev_d = 1'b0;
`endif
        if (in_reseed) begin
          // Restart the seed sequence; a beat offered this cycle is dropped.
          beat_d = 2'd0;
        end else if (in_seed_valid) begin
          unique case (beat_q)
            2'd0: begin
              state_d[31:0] = in_seed;
              beat_d        = 2'd1;
            end
            2'd1: begin
              state_d[63:32] = in_seed;
              beat_d         = 2'd2;
            end
            2'd2: begin
              state_d[95:64] = in_seed;
              beat_d         = 2'd3;
            end
            default: begin
              // An all-zero LFSR would lock up; nudge it to a legal state.
              if (seed_full == '0) begin
                seed_full[0] = 1'b1;
              end
              state_d = seed_full;
              beat_d  = 2'd0;
              fsm_d   = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_RUN;
`ifdef MASKED_PRNG_HEALTH_EN
              error_d = 1'b0;
`endif
            end
          endcase
        end
      end
      ST_WARMUP: begin
        random_d = '0;
`ifdef MASKED_PRNG_HEALTH_EN
        rep_d       = 4'd0;
        have_prev_d = 1'b0;
`endif
        if (in_reseed) begin
          fsm_d  = ST_SEED;
          beat_d = 2'd0;
          warm_d = 8'd0;
        end else begin
          state_d = adv;
          if (warm_q == WARM_LAST) begin
            fsm_d  = ST_RUN;
            warm_d = 8'd0;
          end else begin
            warm_d = warm_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (in_reseed) begin
          // Reseed wins over enable: no advance, output cleared.
          fsm_d    = ST_SEED;
          beat_d   = 2'd0;
          warm_d   = 8'd0;
          random_d = '0;
`ifdef MASKED_PRNG_HEALTH_EN
          rep_d       = 4'd0;
          have_prev_d = 1'b0;
`endif
        end else if (in_enable) begin
          state_d  = adv;
          random_d = adv[OUT_WIDTH-1:0];
          valid_d  = 1'b1;
`ifdef MASKED_PRNG_HEALTH_EN
          // Count consecutive repeats of the previously presented word.
          if (have_prev_q && (adv[OUT_WIDTH-1:0] == random_q)) begin
            rep_next = rep_q + 4'd1;
          end
          rep_d       = rep_next;
          have_prev_d = 1'b1;
          if ((rep_next == REP_LAST) || (adv == '0)) begin
            error_d     = 1'b1;
            fsm_d       = ST_SEED;
            valid_d     = 1'b0;
            random_d    = '0;
            rep_d       = 4'd0;
            have_prev_d = 1'b0;
          end
`endif
        end
      end
      default: begin
        fsm_d    = ST_SEED;
        beat_d   = 2'd0;
        warm_d   = 8'd0;
        random_d = '0;
      end
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      fsm_q    <= ST_SEED;
      state_q  <= '0;
      beat_q   <= 2'd0;
      warm_q   <= 8'd0;
      random_q <= '0;
      valid_q  <= 1'b0;
`ifdef MASKED_PRNG_HEALTH_EN
      rep_q       <= 4'd0;
      have_prev_q <= 1'b0;
      error_q     <= 1'b0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      warm_q   <= warm_d;
      random_q <= random_d;
      valid_q  <= valid_d;
`ifdef MASKED_PRNG_HEALTH_EN
      rep_q       <= rep_d;
      have_prev_q <= have_prev_d;
      error_q     <= error_d;
`endif
    end
  end

endmodule
